// File: rtl/rx_frame_sequencer_if.sv
// Bus bundle between the RX frame sequencer and its environment: RX word stream,
// frame-buffer write port, checker handshake and frame statistics.
interface rx_frame_sequencer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] i_rx_data;
    logic [CTRL_WIDTH-1:0] i_rx_ctrl;
    logic                  o_cap_we;
    logic [7:0]            o_cap_addr;
    logic [DATA_WIDTH-1:0] o_cap_data;
    logic                  o_chk_start;
    logic [10:0]           o_chk_len;
    logic                  i_chk_done;
    logic [3:0]            i_chk_err;
    logic                  o_busy;
    logic [15:0]           o_good_cnt;
    logic [15:0]           o_bad_cnt;
    logic [15:0]           o_drop_cnt;

    // Checker handshake: o_chk_start is a one-cycle pulse carrying o_chk_len; the
    // checker answers with a one-cycle i_chk_done qualifying i_chk_err, and any
    // i_chk_done seen while no check is outstanding is ignored.
    modport master (
        output i_rx_data, i_rx_ctrl, i_chk_done, i_chk_err,
        input  o_cap_we, o_cap_addr, o_cap_data, o_chk_start, o_chk_len,
               o_busy, o_good_cnt, o_bad_cnt, o_drop_cnt
    );

    modport slave (
        input  i_rx_data, i_rx_ctrl, i_chk_done, i_chk_err,
        output o_cap_we, o_cap_addr, o_cap_data, o_chk_start, o_chk_len,
               o_busy, o_good_cnt, o_bad_cnt, o_drop_cnt
    );
endinterface

// File: rtl/rx_frame_sequencer.sv
// Captures start..terminate frames from a lane-oriented RX stream into a word buffer,
// triggers an external checker on length-valid frames and keeps good/bad/drop counts.
module rx_frame_sequencer #(
    parameter int          DATA_WIDTH  = 64,
    parameter int          CTRL_WIDTH  = 8,
    parameter logic [7:0]  IDLE_CODE   = 8'h07,
    parameter logic [7:0]  START_CODE  = 8'hFB,
    parameter logic [7:0]  TERM_CODE   = 8'hFD,
    parameter int          MIN_LEN     = 73,
    parameter int          MAX_LEN     = 1527,
    parameter int          MAX_WORDS   = 191,
    parameter int          CHK_TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               i_rst,
    rx_frame_sequencer_if.slave bus
);
    localparam int         LANE_W      = $clog2(CTRL_WIDTH);
    localparam logic [7:0] MAX_WORDS_W = 8'(MAX_WORDS);
    localparam logic [7:0] TIMEOUT_W   = 8'(CHK_TIMEOUT);
    localparam logic [10:0] MIN_LEN_W  = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W  = 11'(MAX_LEN);

    typedef enum logic [2:0] {IDLE, CAPTURE, CHECK, WAIT, DROP} state_t;

    state_t                state_q, state_d;
    logic [7:0]            word_cnt_q, word_cnt_d;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  cap_we_q, cap_we_d;
    logic [7:0]            cap_addr_q, cap_addr_d;
    logic [DATA_WIDTH-1:0] cap_data_q, cap_data_d;
    logic                  chk_start_q, chk_start_d;
    logic [10:0]           chk_len_q, chk_len_d;
    logic                  busy_q, busy_d;
    logic [15:0]           good_q, good_d;
    logic [15:0]           bad_q, bad_d;
    logic [15:0]           drop_q, drop_d;

    logic                  start_word;
    logic                  idle_word;
    logic                  ctrl_found;
    logic [LANE_W-1:0]     ctrl_lane;
    logic [7:0]            ctrl_byte;
    logic [10:0]           frame_len;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // The lowest control lane decides the word: a terminate there ends the frame,
    // any other control character before a terminate is a protocol error.
    always_comb begin
        start_word = bus.i_rx_ctrl[0] && (bus.i_rx_data[7:0] == START_CODE);
        idle_word  = 1'b1;
        ctrl_found = 1'b0;
        ctrl_lane  = '0;
        ctrl_byte  = '0;
        for (int k = CTRL_WIDTH - 1; k >= 0; k--) begin
            if (!bus.i_rx_ctrl[k] || (bus.i_rx_data[8*k +: 8] != IDLE_CODE)) begin
                idle_word = 1'b0;
            end
            if (bus.i_rx_ctrl[k]) begin
                ctrl_found = 1'b1;
                ctrl_lane  = LANE_W'(k);
                ctrl_byte  = bus.i_rx_data[8*k +: 8];
            end
        end
        frame_len = 11'(word_cnt_q) * 11'(CTRL_WIDTH) + 11'(ctrl_lane) + 11'd1;
    end

    always_comb begin
        state_d     = state_q;
        word_cnt_d  = word_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        cap_we_d    = 1'b0;
        cap_addr_d  = cap_addr_q;
        cap_data_d  = cap_data_q;
        chk_start_d = 1'b0;
        chk_len_d   = chk_len_q;
        good_d      = good_q;
        bad_d       = bad_q;
        drop_d      = drop_q;

        case (state_q)
            IDLE: begin
                if (start_word) begin
                    cap_we_d   = 1'b1;
                    cap_addr_d = '0;
                    cap_data_d = bus.i_rx_data;
                    word_cnt_d = 8'd1;
                    state_d    = CAPTURE;
                end
            end
            CAPTURE: begin
                cap_we_d   = 1'b1;
                cap_addr_d = word_cnt_q;
                cap_data_d = bus.i_rx_data;
                word_cnt_d = word_cnt_q + 8'd1;
                if (ctrl_found && (ctrl_byte != TERM_CODE)) begin
                    state_d = DROP;
                    drop_d  = sat_inc(drop_q);
                end else if (ctrl_found) begin
                    if ((frame_len >= MIN_LEN_W) && (frame_len <= MAX_LEN_W)) begin
                        state_d     = CHECK;
                        chk_start_d = 1'b1;
                        chk_len_d   = frame_len;
                    end else begin
                        state_d = DROP;
                        drop_d  = sat_inc(drop_q);
                    end
                end else if (word_cnt_d == MAX_WORDS_W) begin
                    state_d = DROP;
                    drop_d  = sat_inc(drop_q);
                end
            end
            CHECK: begin
                state_d    = WAIT;
                wait_cnt_d = '0;
                if (start_word) drop_d = sat_inc(drop_q);
            end
            WAIT: begin
                if (start_word) drop_d = sat_inc(drop_q);
                // A done arriving on the timeout cycle still reports the checker verdict.
                if (bus.i_chk_done) begin
                    if (bus.i_chk_err == 4'd0) good_d = sat_inc(good_q);
                    else                       bad_d  = sat_inc(bad_q);
                    state_d = IDLE;
                end else if (wait_cnt_q == TIMEOUT_W) begin
                    bad_d   = sat_inc(bad_q);
                    state_d = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            DROP: begin
                if (idle_word) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            word_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            cap_we_q    <= 1'b0;
            cap_addr_q  <= '0;
            cap_data_q  <= '0;
            chk_start_q <= 1'b0;
            chk_len_q   <= '0;
            busy_q      <= 1'b0;
            good_q      <= '0;
            bad_q       <= '0;
            drop_q      <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            cap_we_q    <= cap_we_d;
            cap_addr_q  <= cap_addr_d;
            cap_data_q  <= cap_data_d;
            chk_start_q <= chk_start_d;
            chk_len_q   <= chk_len_d;
            busy_q      <= busy_d;
            good_q      <= good_d;
            bad_q       <= bad_d;
            drop_q      <= drop_d;
        end
    end

    assign bus.o_cap_we    = cap_we_q;
    assign bus.o_cap_addr  = cap_addr_q;
    assign bus.o_cap_data  = cap_data_q;
    assign bus.o_chk_start = chk_start_q;
    assign bus.o_chk_len   = chk_len_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_good_cnt  = good_q;
    assign bus.o_bad_cnt   = bad_q;
    assign bus.o_drop_cnt  = drop_q;
endmodule

// File: tb/tb_rx_frame_sequencer.sv
// Directed bench for rx_frame_sequencer: minimum, runt, oversize, checker-error,
// timeout, overrun, mid-frame reset and done/timeout tie frames.
module tb_rx_frame_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rx_frame_sequencer_if #(.DATA_WIDTH(64), .CTRL_WIDTH(8)) bus ();
    rx_frame_sequencer dut (.clk(clk), .i_rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    logic [71:0] exp_q[$];

    localparam logic [63:0] START_D = 64'hD555_5555_5555_55FB;
    localparam logic [63:0] IDLE_D  = 64'h0707_0707_0707_0707;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] data_word(input logic [7:0] idx);
        return {8{idx}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    function automatic logic [63:0] term_word(input int k, input logic [7:0] idx);
        logic [63:0] d;
        d = data_word(idx);
        for (int j = k; j < 8; j++) d[8*j +: 8] = (j == k) ? 8'hFD : 8'h07;
        return d;
    endfunction

    // Driver: present one RX word, optionally record the buffer write it must cause.
    task automatic drive(input logic [63:0] d, input logic [7:0] c, input bit wr, input logic [7:0] addr);
        bus.i_rx_data = d;
        bus.i_rx_ctrl = c;
        if (wr) exp_q.push_back({addr, d});
        @(posedge clk);
        #1;
    endtask

    task automatic send_idle();
        drive(IDLE_D, 8'hFF, 1'b0, 8'd0);
    endtask

    task automatic send_start(input bit wr);
        drive(START_D, 8'h01, wr, 8'd0);
    endtask

    task automatic send_data(input logic [7:0] idx, input bit wr);
        drive(data_word(idx), 8'h00, wr, idx);
    endtask

    task automatic send_term(input int k, input logic [7:0] idx);
        drive(term_word(k, idx), 8'hFF << k, 1'b1, idx);
    endtask

    task automatic send_frame(input int n_data, input int term_lane);
        send_start(1'b1);
        for (int i = 1; i <= n_data; i++) send_data(8'(i), 1'b1);
        send_term(term_lane, 8'(n_data + 1));
    endtask

    task automatic pulse_done(input logic [3:0] err);
        bus.i_chk_done = 1'b1;
        bus.i_chk_err  = err;
        send_idle();
        bus.i_chk_done = 1'b0;
        bus.i_chk_err  = 4'd0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_cap_we"},    64'(bus.o_cap_we),    64'd0);
        check({tag, "_cap_addr"},  64'(bus.o_cap_addr),  64'd0);
        check({tag, "_cap_data"},  bus.o_cap_data,       64'd0);
        check({tag, "_chk_start"}, 64'(bus.o_chk_start), 64'd0);
        check({tag, "_chk_len"},   64'(bus.o_chk_len),   64'd0);
        check({tag, "_busy"},      64'(bus.o_busy),      64'd0);
        check({tag, "_good"},      64'(bus.o_good_cnt),  64'd0);
        check({tag, "_bad"},       64'(bus.o_bad_cnt),   64'd0);
        check({tag, "_drop"},      64'(bus.o_drop_cnt),  64'd0);
    endtask

    // Scoreboard: every buffer write must match the oldest expected {addr, data}.
    always @(negedge clk) begin
        if (bus.o_cap_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("cap_we_unexpected", 64'(bus.o_cap_we), 64'd0);
            end else begin
                logic [71:0] e;
                e = exp_q.pop_front();
                check("cap_addr", 64'(bus.o_cap_addr), 64'(e[71:64]));
                check("cap_data", bus.o_cap_data, e[63:0]);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.i_rx_data  = IDLE_D;
        bus.i_rx_ctrl  = 8'hFF;
        bus.i_chk_done = 1'b0;
        bus.i_chk_err  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;
        send_idle();

        // Minimum frame: 73 bytes, check pulse the cycle after the terminate word.
        send_start(1'b1);
        check("min_busy", 64'(bus.o_busy), 64'd1);
        for (int i = 1; i <= 8; i++) send_data(8'(i), 1'b1);
        check("min_no_early_start", 64'(bus.o_chk_start), 64'd0);
        send_term(0, 8'd9);
        check("min_chk_start", 64'(bus.o_chk_start), 64'd1);
        check("min_chk_len", 64'(bus.o_chk_len), 64'd73);
        send_idle();
        check("min_start_one_cycle", 64'(bus.o_chk_start), 64'd0);
        check("min_len_held", 64'(bus.o_chk_len), 64'd73);
        check("min_wait_busy", 64'(bus.o_busy), 64'd1);
        pulse_done(4'd0);
        check("min_good", 64'(bus.o_good_cnt), 64'd1);
        check("min_bad", 64'(bus.o_bad_cnt), 64'd0);
        check("min_idle", 64'(bus.o_busy), 64'd0);

        // Runt: 44 bytes; a stray done during capture is ignored.
        send_start(1'b1);
        send_data(8'd1, 1'b1);
        send_data(8'd2, 1'b1);
        bus.i_chk_done = 1'b1;
        send_data(8'd3, 1'b1);
        bus.i_chk_done = 1'b0;
        check("stray_done_ignored", 64'(bus.o_good_cnt), 64'd1);
        send_data(8'd4, 1'b1);
        send_term(3, 8'd5);
        check("runt_no_chk_start", 64'(bus.o_chk_start), 64'd0);
        check("runt_drop", 64'(bus.o_drop_cnt), 64'd1);
        send_data(8'd6, 1'b0);
        check("runt_drop_busy", 64'(bus.o_busy), 64'd1);
        send_idle();
        check("runt_back_idle", 64'(bus.o_busy), 64'd0);
        check("runt_drop_once", 64'(bus.o_drop_cnt), 64'd1);

        // Oversize: 191 words without a terminate.
        send_start(1'b1);
        for (int i = 1; i <= 189; i++) send_data(8'(i), 1'b1);
        check("over_not_yet", 64'(bus.o_drop_cnt), 64'd1);
        send_data(8'd190, 1'b1);
        check("over_drop", 64'(bus.o_drop_cnt), 64'd2);
        check("over_busy", 64'(bus.o_busy), 64'd1);
        for (int i = 0; i < 3; i++) send_data(8'(i + 7), 1'b0);
        send_idle();
        check("over_back_idle", 64'(bus.o_busy), 64'd0);

        // 100-byte frame rejected by the checker.
        send_frame(11, 3);
        check("err_chk_len", 64'(bus.o_chk_len), 64'd100);
        check("err_chk_start", 64'(bus.o_chk_start), 64'd1);
        send_idle();
        pulse_done(4'b0001);
        check("err_bad", 64'(bus.o_bad_cnt), 64'd1);
        check("err_good_kept", 64'(bus.o_good_cnt), 64'd1);

        // Second frame with no done: timeout on the 257th cycle after the terminate.
        send_frame(11, 3);
        repeat (256) send_idle();
        check("tmo_still_busy", 64'(bus.o_busy), 64'd1);
        check("tmo_bad_before", 64'(bus.o_bad_cnt), 64'd1);
        send_idle();
        check("tmo_bad", 64'(bus.o_bad_cnt), 64'd2);
        check("tmo_idle", 64'(bus.o_busy), 64'd0);

        // Overrun: start word during WAIT.
        send_frame(8, 0);
        send_idle();
        send_start(1'b0);
        check("ovr_drop", 64'(bus.o_drop_cnt), 64'd3);
        check("ovr_no_we", 64'(bus.o_cap_we), 64'd0);
        check("ovr_busy", 64'(bus.o_busy), 64'd1);
        pulse_done(4'd0);
        check("ovr_good", 64'(bus.o_good_cnt), 64'd2);

        // Reset during capture word 4, then a normal frame.
        send_start(1'b1);
        for (int i = 1; i <= 3; i++) send_data(8'(i), 1'b1);
        rst = 1'b1;
        send_data(8'd4, 1'b0);
        rst = 1'b0;
        check_all_zero("midrst");
        send_data(8'd5, 1'b0);
        send_idle();
        check("midrst_no_start", 64'(bus.o_chk_start), 64'd0);
        check("midrst_idle", 64'(bus.o_busy), 64'd0);
        send_frame(8, 0);
        check("post_rst_start", 64'(bus.o_chk_start), 64'd1);
        check("post_rst_len", 64'(bus.o_chk_len), 64'd73);
        send_idle();
        pulse_done(4'd0);
        check("post_rst_good", 64'(bus.o_good_cnt), 64'd1);

        // Done on the timeout cycle wins over the timeout.
        send_frame(8, 0);
        repeat (256) send_idle();
        pulse_done(4'd0);
        check("tie_good", 64'(bus.o_good_cnt), 64'd2);
        check("tie_bad", 64'(bus.o_bad_cnt), 64'd0);
        check("tie_idle", 64'(bus.o_busy), 64'd0);

        send_idle();
        check("writes_all_seen", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rx_frame_sequencer.md
RX_FRAME_SEQUENCER -- requirements
Module: rx_frame_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DATA_WIDTH, 64, RX word width; lane k = bits [8k+7:8k]; lane 0 is first on the wire.
- CTRL_WIDTH, 8, one control bit per lane.
- IDLE_CODE, 8'h07, idle control character.
- START_CODE, 8'hFB, start control character.
- TERM_CODE, 8'hFD, terminate control character.
- MIN_LEN, 73, minimum byte count including start and term (8 + 64 + 1).
- MAX_LEN, 1527, maximum byte count including start and term (8 + 1518 + 1).
- MAX_WORDS, 191, capture word limit.
- CHK_TIMEOUT, 255, cycles to wait for checker done.

REQ-002 Ports, one per line: name, direction, width, meaning. The block has one clock; reset is synchronous and active-high.
- clk, in, 1, clock.
- i_rst, in, 1, synchronous active-high reset.
- i_rx_data, in, 64, RX data word, one per cycle.
- i_rx_ctrl, in, 8, RX lane control flags.
- o_cap_we, out, 1, frame-buffer write enable.
- o_cap_addr, out, 8, frame-buffer word index.
- o_cap_data, out, 64, frame-buffer write data.
- o_chk_start, out, 1, single-cycle checker trigger.
- o_chk_len, out, 11, frame byte count, start through term inclusive.
- i_chk_done, in, 1, checker finished.
- i_chk_err, in, 4, checker errors {fcs, payload, header, preamble}.
- o_busy, out, 1, high in any state other than IDLE.
- o_good_cnt, out, 16, frames accepted.
- o_bad_cnt, out, 16, frames failed by the checker or timed out.
- o_drop_cnt, out, 16, frames dropped before check.

Function
REQ-003 All outputs SHALL be registered.

REQ-004 FSM states SHALL be IDLE, CAPTURE, CHECK, WAIT, DROP.

REQ-005 Start word definition: i_rx_ctrl[0]=1 and lane 0 = START_CODE.

REQ-006 IDLE behaviour:
- On a start word: write it at address 0 (o_cap_we=1 next cycle), set word_cnt=1, go to CAPTURE.
- Otherwise: stay in IDLE with no write.

REQ-007 CAPTURE, each cycle:
- Write i_rx_data at address word_cnt.
- Increment word_cnt.

REQ-008 CAPTURE terminate detection: term lane = the lowest lane k with ctrl[k]=1 and byte = TERM_CODE. If found:
- len = word_cnt*8 + k + 1, computed on the pre-increment word_cnt.
- Go to CHECK if MIN_LEN <= len <= MAX_LEN.
- Otherwise go to DROP.

REQ-009 CAPTURE protocol errors, each going to DROP without searching for a terminate:
- A control lane below the term lane holding a byte other than TERM_CODE.
- A start word.
- word_cnt reaching MAX_WORDS with no terminate found.

REQ-010 CHECK SHALL last exactly one cycle:
- o_chk_start=1 and o_chk_len=len.
- Next state WAIT.
- o_chk_start rises the cycle after the terminate word is sampled.

REQ-011 WAIT SHALL count cycles from 0:
- On i_chk_done with i_chk_err==0: increment o_good_cnt, go to IDLE.
- On i_chk_done with i_chk_err!=0: increment o_bad_cnt, go to IDLE.
- When the count reaches CHK_TIMEOUT without done: increment o_bad_cnt, go to IDLE.
- If done and timeout occur in the same cycle, done SHALL win.

REQ-012 DROP behaviour:
- Increment o_drop_cnt once on entry.
- No buffer writes while in DROP.
- Exit to IDLE on an idle word (all ctrl=1, all lanes=IDLE_CODE).

REQ-013 Overrun: a start word sampled in CHECK or WAIT SHALL increment o_drop_cnt and SHALL NOT write the buffer or change state.

REQ-014 i_chk_done outside WAIT SHALL be ignored.

REQ-015 Counters SHALL saturate at 16'hFFFF.

REQ-016 o_cap_we SHALL be 0 except in the cycle after an IDLE start word or a CAPTURE cycle.

REQ-017 o_chk_len SHALL hold its value until the next CHECK.

Reset
REQ-018 When i_rst=1 at a clock edge:
- State IDLE, word_cnt=0, WAIT counter=0.
- o_cap_we=0, o_cap_addr=0, o_cap_data=0.
- o_chk_start=0, o_chk_len=0, o_busy=0.
- All counters 0.

REQ-019 Reset mid-frame SHALL abandon the frame with no o_chk_start and no counter change after release.

Verification
REQ-020 Minimum frame: start word, words 1-8 data, term in lane 0 of word 9 -> o_chk_start one cycle after word 9, o_chk_len=73, writes to addresses 0..9; done with err=0 -> o_good_cnt=1.

REQ-021 Runt: term in lane 3 of word 5 (len=44) -> no o_chk_start, o_drop_cnt=1, return to IDLE on the next idle word.

REQ-022 Oversize: 191 words with no term -> DROP, o_drop_cnt=1, no writes while in DROP.

REQ-023 Checker error: valid 100-byte frame, done with err=4'b0001 -> o_bad_cnt=1; a second frame with no done for 255 cycles -> o_bad_cnt=2.

REQ-024 Overrun: start word during WAIT -> o_drop_cnt+1, no o_cap_we, WAIT unaffected.

REQ-025 Reset in CAPTURE word 4 -> all outputs 0 the next cycle; the following valid frame is checked normally.
